button_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the lab5 multiplier top level. It synchronizes and debounces the raw active-low Run and ClearA_LoadB pushbuttons, turns each press into one clean single-cycle pulse, and captures the switch operand at the moment of a load press. The multiplier control FSM therefore sees exactly one start or load event per physical press, and a stable operand.

---
 rtl/button_conditioner.sv | 194 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Input conditioner for the lab5 multiplier: synchronizes and debounces the
// active-low Run and ClearA_LoadB buttons, emits one pulse per press, latches SW.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       ClearA_LoadB_n,
  input  logic [7:0] SW,
  output logic       Run_pulse,
  output logic       ClearA_LoadB_pulse,
  output logic       Run_level,
  output logic [7:0] SW_hold
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic       run_s1_q, run_s2_q;
  logic       ld_s1_q, ld_s2_q;
  logic [7:0] sw_s1_q, sw_s2_q;

  db_state_e            run_state_q, ld_state_q;
  logic [CNT_WIDTH-1:0] run_cnt_q, ld_cnt_q;
  logic                 run_evt_q, ld_evt_q;

  logic run_pending_q, run_pending_d;
  logic run_pulse_d;
  logic run_fire;

  // Two-flop synchronizers; released (1) is the reset value for every stage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_s1_q <= 1'b1;
      run_s2_q <= 1'b1;
      ld_s1_q  <= 1'b1;
      ld_s2_q  <= 1'b1;
      sw_s1_q  <= '1;
      sw_s2_q  <= '1;
    end else begin
      run_s1_q <= Run_n;
      run_s2_q <= run_s1_q;
      ld_s1_q  <= ClearA_LoadB_n;
      ld_s2_q  <= ld_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_state_q <= RELEASED;
      run_cnt_q   <= '0;
      run_evt_q   <= 1'b0;
      Run_level   <= 1'b0;
    end else begin
      run_evt_q <= 1'b0;
      Run_level <= (run_state_q == PRESSED) || (run_state_q == RELEASE_WAIT);
      case (run_state_q)
        RELEASED: begin
          if (!run_s2_q) begin
            run_state_q <= PRESS_WAIT;
            run_cnt_q   <= CNT_ONE;
          end else begin
            run_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (run_s2_q) begin
            run_state_q <= RELEASED;
            run_cnt_q   <= '0;
          end else if (run_cnt_q == CNT_LAST) begin
            run_state_q <= PRESSED;
            run_cnt_q   <= '0;
            run_evt_q   <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (run_s2_q) begin
            run_state_q <= RELEASE_WAIT;
            run_cnt_q   <= CNT_ONE;
          end else begin
            run_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!run_s2_q) begin
            run_state_q <= PRESSED;
            run_cnt_q   <= '0;
          end else if (run_cnt_q == CNT_LAST) begin
            run_state_q <= RELEASED;
            run_cnt_q   <= '0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        default: begin
          run_state_q <= RELEASED;
          run_cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ld_state_q <= RELEASED;
      ld_cnt_q   <= '0;
      ld_evt_q   <= 1'b0;
    end else begin
      ld_evt_q <= 1'b0;
      case (ld_state_q)
        RELEASED: begin
          if (!ld_s2_q) begin
            ld_state_q <= PRESS_WAIT;
            ld_cnt_q   <= CNT_ONE;
          end else begin
            ld_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (ld_s2_q) begin
            ld_state_q <= RELEASED;
            ld_cnt_q   <= '0;
          end else if (ld_cnt_q == CNT_LAST) begin
            ld_state_q <= PRESSED;
            ld_cnt_q   <= '0;
            ld_evt_q   <= 1'b1;
          end else begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (ld_s2_q) begin
            ld_state_q <= RELEASE_WAIT;
            ld_cnt_q   <= CNT_ONE;
          end else begin
            ld_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!ld_s2_q) begin
            ld_state_q <= PRESSED;
            ld_cnt_q   <= '0;
          end else if (ld_cnt_q == CNT_LAST) begin
            ld_state_q <= RELEASED;
            ld_cnt_q   <= '0;
          end else begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
          end
        end
        default: begin
          ld_state_q <= RELEASED;
          ld_cnt_q   <= '0;
        end
      endcase
    end
  end

  // A load event wins the cycle; a coincident Run event is deferred one cycle.
  always_comb begin
    run_fire      = run_evt_q | run_pending_q;
    run_pulse_d   = run_fire & ~ld_evt_q;
    run_pending_d = run_fire & ld_evt_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Run_pulse          <= 1'b0;
      ClearA_LoadB_pulse <= 1'b0;
      run_pending_q      <= 1'b0;
      SW_hold            <= 8'h00;
    end else begin
      Run_pulse          <= run_pulse_d;
      ClearA_LoadB_pulse <= ld_evt_q;
      run_pending_q      <= run_pending_d;
      if (ld_evt_q) begin
        SW_hold <= sw_s2_q;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4: expected
// pulses are queued with their due cycle and matched when the DUT emits them.
module tb_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned LAT = DB + 2;

  logic       Clk;
  logic       Reset;
  logic       Run_n;
  logic       ClearA_LoadB_n;
  logic [7:0] SW;
  logic       Run_pulse;
  logic       ClearA_LoadB_pulse;
  logic       Run_level;
  logic [7:0] SW_hold;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  sw;
  } exp_t;

  exp_t run_q[$];
  exp_t load_q[$];
  exp_t e;

  int unsigned cyc;
  int n_cmp;
  int n_bad;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(3)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run_n(Run_n),
    .ClearA_LoadB_n(ClearA_LoadB_n),
    .SW(SW),
    .Run_pulse(Run_pulse),
    .ClearA_LoadB_pulse(ClearA_LoadB_pulse),
    .Run_level(Run_level),
    .SW_hold(SW_hold)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic push_run(input int unsigned c);
    exp_t x;
    x.cyc = c;
    x.sw  = 8'h00;
    run_q.push_back(x);
  endtask

  task automatic push_load(input int unsigned c, input logic [7:0] s);
    exp_t x;
    x.cyc = c;
    x.sw  = s;
    load_q.push_back(x);
  endtask

  // Sampled 1 time unit after each rising edge; cyc then names that edge.
  always @(posedge Clk) begin
    #1;
    if (Run_pulse || ClearA_LoadB_pulse)
      check("no_overlap", {31'b0, Run_pulse & ClearA_LoadB_pulse}, 32'd0);
    if (Run_pulse) begin
      if (run_q.size() == 0) check("run_unexpected", 32'd1, 32'd0);
      else begin
        e = run_q.pop_front();
        check("run_cycle", cyc, e.cyc);
      end
    end
    if (ClearA_LoadB_pulse) begin
      if (load_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
      else begin
        e = load_q.pop_front();
        check("load_cycle", cyc, e.cyc);
        check("load_sw_hold", {24'b0, SW_hold}, {24'b0, e.sw});
      end
    end
    while (run_q.size() > 0 && run_q[0].cyc < cyc) begin
      e = run_q.pop_front();
      check("run_missing", cyc, e.cyc);
    end
    while (load_q.size() > 0 && load_q[0].cyc < cyc) begin
      e = load_q.pop_front();
      check("load_missing", cyc, e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned r;
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    SW = 8'h00;

    wait_cyc(2);
    check("rst_run_pulse", {31'b0, Run_pulse}, 32'd0);
    check("rst_load_pulse", {31'b0, ClearA_LoadB_pulse}, 32'd0);
    check("rst_run_level", {31'b0, Run_level}, 32'd0);
    check("rst_sw_hold", {24'b0, SW_hold}, 32'h00);
    Reset = 1'b0;
    wait_cyc(6);

    // Clean Run press held ~20 cycles, then clean release.
    k = cyc + 1;
    Run_n = 1'b0;
    push_run(k + LAT);
    wait_cyc(k + LAT - 1);
    check("press_level_before", {31'b0, Run_level}, 32'd0);
    wait_cyc(k + LAT);
    check("press_level_after", {31'b0, Run_level}, 32'd1);
    wait_cyc(k + 20);
    check("held_level", {31'b0, Run_level}, 32'd1);
    r = cyc + 1;
    Run_n = 1'b1;
    wait_cyc(r + LAT - 1);
    check("release_level_before", {31'b0, Run_level}, 32'd1);
    wait_cyc(r + LAT);
    check("release_level_after", {31'b0, Run_level}, 32'd0);
    wait_cyc(r + 12);

    // Glitch of DB-1 samples is rejected.
    k = cyc + 1;
    Run_n = 1'b0;
    wait_cyc(k + DB - 2);
    Run_n = 1'b1;
    wait_cyc(k + 16);
    check("glitch_level", {31'b0, Run_level}, 32'd0);

    // Exactly DB low samples is the shortest accepted press.
    k = cyc + 1;
    Run_n = 1'b0;
    push_run(k + LAT);
    wait_cyc(k + DB - 1);
    Run_n = 1'b1;
    wait_cyc(k + LAT);
    check("min_press_level", {31'b0, Run_level}, 32'd1);
    wait_cyc(k + 20);
    check("min_press_released", {31'b0, Run_level}, 32'd0);

    // Load capture, SW motion without a press, second capture.
    SW = 8'h03;
    wait_cyc(cyc + 4);
    k = cyc + 1;
    ClearA_LoadB_n = 1'b0;
    push_load(k + LAT, 8'h03);
    wait_cyc(k + 15);
    ClearA_LoadB_n = 1'b1;
    wait_cyc(k + 30);
    SW = 8'hFD;
    wait_cyc(cyc + 10);
    check("sw_hold_kept", {24'b0, SW_hold}, 32'h03);
    k = cyc + 1;
    ClearA_LoadB_n = 1'b0;
    push_load(k + LAT, 8'hFD);
    wait_cyc(k + 15);
    ClearA_LoadB_n = 1'b1;
    wait_cyc(k + 30);
    check("sw_hold_second", {24'b0, SW_hold}, 32'hFD);

    // Simultaneous presses: load first, Run one cycle later.
    k = cyc + 1;
    Run_n = 1'b0;
    ClearA_LoadB_n = 1'b0;
    push_load(k + LAT, 8'hFD);
    push_run(k + LAT + 1);
    wait_cyc(k + 15);
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    wait_cyc(k + 30);

    // Reset while Run counter is at 2 aborts the debounce; restart is full latency.
    k = cyc + 1;
    Run_n = 1'b0;
    wait_cyc(k + 3);
    Reset = 1'b1;
    wait_cyc(k + 5);
    check("midrst_run_level", {31'b0, Run_level}, 32'd0);
    check("midrst_sw_hold", {24'b0, SW_hold}, 32'h00);
    Reset = 1'b0;
    push_run(k + 6 + LAT);
    wait_cyc(k + 6 + LAT - 1);
    check("midrst_level_before", {31'b0, Run_level}, 32'd0);
    wait_cyc(k + 6 + LAT);
    check("midrst_level_after", {31'b0, Run_level}, 32'd1);
    wait_cyc(k + 25);
    Run_n = 1'b1;
    wait_cyc(k + 45);

    check("run_queue_drained", run_q.size(), 32'd0);
    check("load_queue_drained", load_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
